// File: rtl/gfx_pkg.sv
`default_nettype none
// ============================================================================
//  gfx_pkg
//  Shared constants, capture state encoding and pixel addressing helpers for
//  the LED matrix scan-out path.
//  Revision: 1.0
// ============================================================================
package gfx_pkg;

    localparam int FB_DIM = 8;                 // matrix is FB_DIM x FB_DIM
    localparam int PIX_W  = 4;                 // bits of intensity per pixel
    localparam int NPIX   = FB_DIM * FB_DIM;   // pixels per frame

    typedef enum logic [0:0] {
        CAP_IDLE = 1'b0,
        CAP_RUN  = 1'b1
    } cap_state_t;

    // Pixel k of the stream lands at row k[5:3], column k[2:0].
    function automatic logic [2:0] pix_row(input logic [5:0] idx);
        return idx[5:3];
    endfunction

    function automatic logic [2:0] pix_col(input logic [5:0] idx);
        return idx[2:0];
    endfunction

    function automatic logic [5:0] pix_index(input logic [2:0] row,
                                             input logic [2:0] col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_row_scanner.sv
`default_nettype none
// ============================================================================
//  pwm_row_scanner
//  Row-scanning PWM engine for an 8x8 LED matrix. A prescaler divides the
//  clock into PWM steps; 16 steps make one row dwell; 8 rows make one
//  display frame. The row/column outputs are registered together so they
//  never skew against each other.
//
//  Ports:
//    clk, rst_n          clock, synchronous active-low reset
//    i_row_word          8 x 4-bit intensities of the row being scanned
//                        (column c in bits [4c+3:4c])
//    o_row_addr          row whose intensities must be presented on i_row_word
//    o_frame_boundary    high in the last cycle of row 7's dwell
//    o_row_sel           one-hot row drive (registered)
//    o_col_data          column drive, bit c = column c (registered)
//  Revision: 1.0
// ============================================================================
module pwm_row_scanner
    import gfx_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [FB_DIM*PIX_W-1:0]   i_row_word,
    output logic [2:0]                o_row_addr,
    output logic                      o_frame_boundary,
    output logic [FB_DIM-1:0]         o_row_sel,
    output logic [FB_DIM-1:0]         o_col_data
);

    localparam logic [7:0] C_PRE_MAX = 8'(PRESCALE - 1);

    logic [7:0]        r_pre;
    logic [3:0]        r_pwm;
    logic [2:0]        r_row;

    logic              w_step;
    logic              w_row_end;
    logic [FB_DIM-1:0] w_col;

    assign w_step           = (r_pre == C_PRE_MAX);
    assign w_row_end        = w_step && (r_pwm == 4'hF);
    assign o_frame_boundary = w_row_end && (r_row == 3'd7);
    assign o_row_addr       = r_row;

    // A column is lit while its intensity exceeds the current PWM step, so
    // intensity 0 never lights and 15 lights for 15 of 16 steps.
    always_comb begin
        w_col = '0;
        for (int c = 0; c < FB_DIM; c++) begin
            w_col[c] = (i_row_word[c*PIX_W +: PIX_W] > r_pwm);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pre      <= '0;
            r_pwm      <= '0;
            r_row      <= '0;
            o_row_sel  <= 8'h01;
            o_col_data <= '0;
        end else begin
            r_pre <= w_step ? 8'd0 : r_pre + 8'd1;
            if (w_step) begin
                r_pwm <= r_pwm + 4'd1;
            end
            if (w_row_end) begin
                r_row <= r_row + 3'd1;
            end
            o_row_sel  <= 8'h01 << r_row;
            o_col_data <= w_col;
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_matrix_scanout.sv
`default_nettype none
// ============================================================================
//  led_matrix_scanout
//  Captures 64-pixel frames from the graphics processor stream into a back
//  buffer and swaps it to the front at display-frame boundaries; the front
//  buffer is scanned onto an 8x8 LED matrix with 4-bit PWM.
//
//  Ports:
//    clk, rst_n      clock, synchronous active-low reset
//    frame_start     one-cycle pulse; pixels 0..63 follow on the next cycles
//    pixel_data      4-bit pixel intensity
//    row_sel         one-hot row drive, active-high
//    col_data        column drive, active-high, bit c = column c
//    frame_done      one-cycle pulse after a complete frame was captured
//    frame_dropped   one-cycle pulse after a partial capture was abandoned
//  Revision: 1.0
// ============================================================================
module led_matrix_scanout
    import gfx_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [3:0]       pixel_data,
    output logic [7:0]       row_sel,
    output logic [7:0]       col_data,
    output logic             frame_done,
    output logic             frame_dropped
);

    cap_state_t                r_state;
    logic [5:0]                r_pix_cnt;
    logic                      r_pending;
    logic                      r_sel;      // 0: buf0 is front, 1: buf1 is front
    logic                      r_frame_done;
    logic                      r_frame_dropped;
    logic [PIX_W-1:0]          r_buf0 [NPIX];
    logic [PIX_W-1:0]          r_buf1 [NPIX];

    logic [2:0]                w_row_addr;
    logic                      w_boundary;
    logic [FB_DIM*PIX_W-1:0]   w_row_word;
    logic                      w_wr;

    // A frame_start during capture restarts the frame, so that cycle's bus
    // value is not a pixel and is not stored.
    assign w_wr = (r_state == CAP_RUN) && !frame_start;

    assign frame_done    = r_frame_done;
    assign frame_dropped = r_frame_dropped;

    // Front buffer row read for the scanner.
    always_comb begin
        w_row_word = '0;
        for (int c = 0; c < FB_DIM; c++) begin
            w_row_word[c*PIX_W +: PIX_W] = r_sel
                ? r_buf1[pix_index(w_row_addr, 3'(c))]
                : r_buf0[pix_index(w_row_addr, 3'(c))];
        end
    end

    // Capture writes only the back buffer (the one not selected by r_sel).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NPIX; i++) begin
                r_buf0[i] <= '0;
                r_buf1[i] <= '0;
            end
        end else if (w_wr) begin
            if (r_sel) begin
                r_buf0[r_pix_cnt] <= pixel_data;
            end else begin
                r_buf1[r_pix_cnt] <= pixel_data;
            end
        end
    end

    // Capture FSM and buffer swap. The swap is evaluated first so that a
    // capture event in the same cycle has the final say on r_pending.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= CAP_IDLE;
            r_pix_cnt       <= '0;
            r_pending       <= 1'b0;
            r_sel           <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_dropped <= 1'b0;
        end else begin
            r_frame_done    <= 1'b0;
            r_frame_dropped <= 1'b0;

            if (w_boundary && r_pending) begin
                r_sel     <= ~r_sel;
                r_pending <= 1'b0;
            end

            case (r_state)
                CAP_IDLE: begin
                    if (frame_start) begin
                        r_pix_cnt <= '0;
                        r_pending <= 1'b0;
                        r_state   <= CAP_RUN;
                    end
                end
                CAP_RUN: begin
                    if (frame_start) begin
                        r_pix_cnt       <= '0;
                        r_frame_dropped <= 1'b1;
                    end else if (r_pix_cnt == 6'd63) begin
                        r_pix_cnt    <= '0;
                        r_pending    <= 1'b1;
                        r_frame_done <= 1'b1;
                        r_state      <= CAP_IDLE;
                    end else begin
                        r_pix_cnt <= r_pix_cnt + 6'd1;
                    end
                end
                default: r_state <= CAP_IDLE;
            endcase
        end
    end

    pwm_row_scanner #(
        .PRESCALE (PRESCALE)
    ) u_scanner (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_row_word       (w_row_word),
        .o_row_addr       (w_row_addr),
        .o_frame_boundary (w_boundary),
        .o_row_sel        (row_sel),
        .o_col_data       (col_data)
    );

endmodule
`default_nettype wire
